pc_sequencer: RTL and testbench

- Fetch-stage controller that owns the architectural PC register and sequences it each cycle for the 5-stage MIPS pipeline.
- Chooses between sequential fetch, a D-stage redirect (branch/jump target from the next-PC logic) and freeze (hazard stall).
- Enforces MIPS delay-slot timing, traps misaligned targets into a HALT state, and counts fetched instructions for the bench.
- Sits between the hazard unit, the D-stage next-PC logic and the IM.

---
 rtl/pc_sequencer_pkg.sv | 26 ++
 rtl/pc_sequencer_if.sv | 28 ++
 rtl/pc_next_mux.sv | 48 ++++
 rtl/pc_sequencer.sv | 64 ++++++
 tb/tb_pc_sequencer.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared constants and types for the fetch-stage PC sequencer.
//   - PCS_* : 2-bit FSM state codes (RUN/STALL/HALT, 3 is illegal)
//   - RESET_PC_DEF : default text-segment base loaded on reset
//   - ALIGN_MASK   : low address bits that must be zero for a word fetch
//   - pc_next_t    : result bundle of the next-PC priority select
package pc_sequencer_pkg;

  localparam logic [1:0]  PCS_RUN   = 2'd0;
  localparam logic [1:0]  PCS_STALL = 2'd1;
  localparam logic [1:0]  PCS_HALT  = 2'd2;
  localparam logic [1:0]  PCS_ILL   = 2'd3;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] ALIGN_MASK   = 32'h0000_0003;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  state;
    logic        set_mis;
  } pc_next_t;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr & ALIGN_MASK) == 32'h0;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control/status bundle between hazard unit, next-PC logic,
// IM and the PC sequencer. Names are from the sequencer's point of view.
//   slave  : the sequencer (consumes i_*, produces o_*)
//   master : the environment driving stall/redirect/halt and reading the PC
interface pc_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             i_stall;
  logic             i_redirect;
  logic [31:0]      i_target;
  logic             i_halt;
  logic [31:0]      o_PC;
  logic [31:0]      o_PC4;
  logic             o_fetch_valid;
  logic             o_misalign;
  logic [1:0]       o_state;
  logic [CNT_W-1:0] o_fetch_cnt;

  modport slave (
    input  i_stall, i_redirect, i_target, i_halt,
    output o_PC, o_PC4, o_fetch_valid, o_misalign, o_state, o_fetch_cnt
  );

  modport master (
    output i_stall, i_redirect, i_target, i_halt,
    input  o_PC, o_PC4, o_fetch_valid, o_misalign, o_state, o_fetch_cnt
  );
endinterface

// File: rtl/pc_next_mux.sv
// pc_next_mux: combinational priority select for the next PC and FSM state.
// Ports:
//   i_state, i_pc              : current registered state and PC
//   i_stall, i_redirect,
//   i_target, i_halt           : control inputs from hazard / D-stage logic
//   o_nxt                      : next pc, next state, misalign set strobe
module pc_next_mux
  import pc_sequencer_pkg::*;
(
  input  logic [1:0]  i_state,
  input  logic [31:0] i_pc,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_target,
  input  logic        i_halt,
  output pc_next_t    o_nxt
);

  always_comb begin
    o_nxt.pc      = i_pc;
    o_nxt.state   = i_state;
    o_nxt.set_mis = 1'b0;
    case (i_state)
      PCS_RUN, PCS_STALL: begin
        if (i_halt) begin
          // halt beats a simultaneous redirect; the target is dropped
          o_nxt.state = PCS_HALT;
        end else if (i_stall) begin
          // D is frozen and will present its redirect again on release
          o_nxt.state = PCS_STALL;
        end else if (i_redirect && !is_aligned(i_target)) begin
          o_nxt.state   = PCS_HALT;
          o_nxt.set_mis = 1'b1;
        end else if (i_redirect) begin
          // delay slot already in F; target fetched on the next cycle
          o_nxt.pc    = i_target;
          o_nxt.state = PCS_RUN;
        end else begin
          o_nxt.pc    = i_pc + 32'd4;
          o_nxt.state = PCS_RUN;
        end
      end
      PCS_HALT: o_nxt.state = PCS_HALT;
      default:  o_nxt.state = PCS_HALT;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage controller owning the architectural PC.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (wins over all inputs)
//   bus   : pc_sequencer_if.slave
//           in : i_stall, i_redirect, i_target, i_halt
//           out: o_PC, o_PC4, o_fetch_valid, o_misalign, o_state, o_fetch_cnt
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 32
) (
  input  logic            clk,
  input  logic            reset,
  pc_sequencer_if.slave   bus
);

  logic [31:0]      r_pc;
  logic [1:0]       r_state;
  logic             r_mis;
  logic [CNT_W-1:0] r_cnt;

  pc_next_t         w_nxt;
  logic             w_fetch_valid;
  logic             w_cnt_en;

  pc_next_mux u_mux (
    .i_state    (r_state),
    .i_pc       (r_pc),
    .i_stall    (bus.i_stall),
    .i_redirect (bus.i_redirect),
    .i_target   (bus.i_target),
    .i_halt     (bus.i_halt),
    .o_nxt      (w_nxt)
  );

  assign w_fetch_valid = (r_state == PCS_RUN) && !bus.i_stall;
  // a fetch in a cycle that is leaving to HALT is not accepted
  assign w_cnt_en      = w_fetch_valid && (w_nxt.state != PCS_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_state <= PCS_RUN;
      r_mis   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_pc    <= w_nxt.pc;
      r_state <= w_nxt.state;
      if (w_nxt.set_mis) r_mis <= 1'b1;
      if (w_cnt_en && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.o_PC          = r_pc;
  assign bus.o_PC4         = r_pc + 32'd4;
  assign bus.o_fetch_valid = w_fetch_valid;
  assign bus.o_misalign    = r_mis;
  assign bus.o_state       = r_state;
  assign bus.o_fetch_cnt   = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic reset2;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.CNT_W(32)) bus  ();
  pc_sequencer_if #(.CNT_W(3))  bus2 ();

  pc_sequencer #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // wrap / saturation variant
  pc_sequencer #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(3)) dut2 (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic        halt;
    logic [31:0] pc;
    logic        vld;
    logic        mis;
    logic [1:0]  st;
    logic [31:0] cnt;
  } vec_t;

  vec_t tv[31];

  function automatic vec_t mk(logic rst, logic stall, logic redir, logic [31:0] tgt,
                              logic halt, logic [31:0] pc, logic vld, logic mis,
                              logic [1:0] st, logic [31:0] cnt);
    vec_t v;
    v.rst = rst; v.stall = stall; v.redir = redir; v.tgt = tgt; v.halt = halt;
    v.pc = pc; v.vld = vld; v.mis = mis; v.st = st; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst stall redir tgt halt | pc vld mis st cnt   (outputs seen before the edge)
    tv[0]  = mk(0,0,0,32'h0,   0, 32'h3000,1,0,0,0);
    tv[1]  = mk(0,0,0,32'h0,   0, 32'h3004,1,0,0,1);
    tv[2]  = mk(0,0,1,32'h3020,0, 32'h3008,1,0,0,2);  // delay slot fetched
    tv[3]  = mk(0,0,0,32'h0,   0, 32'h3020,1,0,0,3);
    tv[4]  = mk(0,0,0,32'h0,   0, 32'h3024,1,0,0,4);
    tv[5]  = mk(0,0,0,32'h0,   0, 32'h3028,1,0,0,5);
    tv[6]  = mk(0,1,1,32'h3100,0, 32'h302C,0,0,0,6);
    tv[7]  = mk(0,1,1,32'h3100,0, 32'h302C,0,0,1,6);
    tv[8]  = mk(0,1,1,32'h3100,0, 32'h302C,0,0,1,6);
    tv[9]  = mk(0,0,1,32'h3100,0, 32'h302C,0,0,1,6);  // release, redirect applied
    tv[10] = mk(0,0,0,32'h0,   0, 32'h3100,1,0,0,6);
    tv[11] = mk(0,0,1,32'h3002,0, 32'h3104,1,0,0,7);  // misaligned
    tv[12] = mk(0,0,0,32'h0,   0, 32'h3104,0,1,2,7);
    tv[13] = mk(0,1,1,32'h3200,0, 32'h3104,0,1,2,7);
    tv[14] = mk(0,0,0,32'h0,   1, 32'h3104,0,1,2,7);
    tv[15] = mk(1,0,0,32'h0,   0, 32'h3104,0,1,2,7);
    tv[16] = mk(0,0,0,32'h0,   0, 32'h3000,1,0,0,0);
    tv[17] = mk(0,0,1,32'h4000,1, 32'h3004,1,0,0,1);  // halt beats redirect
    tv[18] = mk(0,0,0,32'h0,   0, 32'h3004,0,0,2,1);
    tv[19] = mk(1,1,1,32'h4000,1, 32'h3004,0,0,2,1);  // reset wins
    tv[20] = mk(0,0,0,32'h0,   0, 32'h3000,1,0,0,0);
    tv[21] = mk(0,1,0,32'h0,   0, 32'h3004,0,0,0,1);
    tv[22] = mk(1,1,0,32'h0,   0, 32'h3004,0,0,1,1);  // reset mid-stall
    tv[23] = mk(0,0,0,32'h0,   0, 32'h3000,1,0,0,0);
    tv[24] = mk(0,1,0,32'h0,   0, 32'h3004,0,0,0,1);
    tv[25] = mk(0,0,0,32'h0,   1, 32'h3004,0,0,1,1);  // halt from STALL
    tv[26] = mk(0,0,0,32'h0,   0, 32'h3004,0,0,2,1);
    tv[27] = mk(1,0,0,32'h0,   0, 32'h3004,0,0,2,1);
    tv[28] = mk(0,1,1,32'h3001,0, 32'h3000,0,0,0,0);  // misaligned redirect ignored while stalled
    tv[29] = mk(0,0,0,32'h0,   0, 32'h3000,0,0,1,0);
    tv[30] = mk(0,0,0,32'h0,   0, 32'h3004,1,0,0,0);

    bus.i_stall = 0; bus.i_redirect = 0; bus.i_target = 0; bus.i_halt = 0;
    bus2.i_stall = 0; bus2.i_redirect = 0; bus2.i_target = 0; bus2.i_halt = 0;
    reset = 1; reset2 = 1;
    tick();
    tick();
    reset = 0;

    for (int i = 0; i < 31; i++) begin
      reset          = tv[i].rst;
      bus.i_stall    = tv[i].stall;
      bus.i_redirect = tv[i].redir;
      bus.i_target   = tv[i].tgt;
      bus.i_halt     = tv[i].halt;
      @(negedge clk);
      chk($sformatf("v%0d pc", i),  bus.o_PC, tv[i].pc);
      chk($sformatf("v%0d pc4", i), bus.o_PC4, tv[i].pc + 32'd4);
      chk($sformatf("v%0d vld", i), {31'b0, bus.o_fetch_valid}, {31'b0, tv[i].vld});
      chk($sformatf("v%0d mis", i), {31'b0, bus.o_misalign}, {31'b0, tv[i].mis});
      chk($sformatf("v%0d st", i),  {30'b0, bus.o_state}, {30'b0, tv[i].st});
      chk($sformatf("v%0d cnt", i), bus.o_fetch_cnt, tv[i].cnt);
      tick();
    end
    reset = 0;

    // wrap variant: PC4 crosses 0xFFFF_FFFC -> 0, 3-bit counter saturates at 7
    reset2 = 0;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] epc;
      logic [31:0] ecnt;
      epc  = 32'hFFFF_FFF8 + 32'(4 * i);
      ecnt = (i > 7) ? 32'd7 : 32'(i);
      @(negedge clk);
      chk($sformatf("w%0d pc", i),  bus2.o_PC, epc);
      chk($sformatf("w%0d pc4", i), bus2.o_PC4, epc + 32'd4);
      chk($sformatf("w%0d cnt", i), {29'b0, bus2.o_fetch_cnt}, ecnt);
      chk($sformatf("w%0d x", i),
          {31'b0, $isunknown({bus2.o_PC, bus2.o_PC4, bus2.o_fetch_valid,
                              bus2.o_misalign, bus2.o_state, bus2.o_fetch_cnt})}, 32'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
